// File: rtl/excp_ctrl_pkg.sv
// Shared widths, exception codes and csr_bus layout for the EXE-stage exception arbiter.
package excp_ctrl_pkg;

  localparam int CSR_BUS_WD = 82;
  localparam int NUM_EXCP   = 7;

  // Ecode values as seen by the CSR file
  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;
  localparam logic [5:0] ECODE_IPE = 6'h0E;

  localparam logic [8:0] ESUBCODE_ADEF = 9'd0;
  localparam logic [8:0] ESUBCODE_ADEM = 9'd1;

  // Bit positions inside ex_excp
  localparam int EXCP_ADEF = 0;
  localparam int EXCP_INE  = 1;
  localparam int EXCP_IPE  = 2;
  localparam int EXCP_SYS  = 3;
  localparam int EXCP_BRK  = 4;
  localparam int EXCP_ALE  = 5;
  localparam int EXCP_ADEM = 6;

  typedef struct packed {
    logic        is_etrn;
    logic        in_excp;
    logic [5:0]  ecode;
    logic [8:0]  subecode;
    logic [31:0] era;
    logic        use_badv;
    logic [31:0] badv;
  } csr_bus_t;

endpackage

// File: rtl/excp_prio_enc.sv
// Combinational priority encoder: picks the highest-priority pending cause and
// returns its ecode/subcode and bad-address information.
module excp_prio_enc
  import excp_ctrl_pkg::*;
(
  input  logic [NUM_EXCP-1:0] excp,
  input  logic                have_intrpt,
  input  logic [31:0]         ex_pc,
  input  logic [31:0]         ex_badv,
  output logic                sel,
  output logic [5:0]          ecode,
  output logic [8:0]          subecode,
  output logic                use_badv,
  output logic [31:0]         badv
);

  // Index 0 is the interrupt, then the flags in ascending bit order,
  // which is also their priority order.
  logic [NUM_EXCP:0] req;
  logic [NUM_EXCP:0] grant;

  assign req = {excp, have_intrpt};
  assign sel = |req;

  generate
    for (genvar gi = 0; gi <= NUM_EXCP; gi++) begin : g_grant
      if (gi == 0) begin : g_top
        assign grant[gi] = req[gi];
      end else begin : g_rest
        assign grant[gi] = req[gi] & ~(|req[gi-1:0]);
      end
    end
  endgenerate

  // grant is one-hot, so the independent ifs never conflict
  always_comb begin
    ecode    = ECODE_INT;
    subecode = ESUBCODE_ADEF;
    use_badv = 1'b0;
    badv     = 32'h0;
    if (grant[EXCP_ADEF+1]) begin
      ecode    = ECODE_ADE;
      use_badv = 1'b1;
      badv     = ex_pc;
    end
    if (grant[EXCP_INE+1]) ecode = ECODE_INE;
    if (grant[EXCP_IPE+1]) ecode = ECODE_IPE;
    if (grant[EXCP_SYS+1]) ecode = ECODE_SYS;
    if (grant[EXCP_BRK+1]) ecode = ECODE_BRK;
    if (grant[EXCP_ALE+1]) begin
      ecode    = ECODE_ALE;
      use_badv = 1'b1;
      badv     = ex_badv;
    end
    if (grant[EXCP_ADEM+1]) begin
      ecode    = ECODE_ADE;
      subecode = ESUBCODE_ADEM;
      use_badv = 1'b1;
      badv     = ex_badv;
    end
  end

endmodule

// File: rtl/excp_ctrl.sv
// EXE-stage exception/interrupt arbiter: builds csr_bus, replays rejected
// events from a saved copy and sequences the pipeline flush.
module excp_ctrl
  import excp_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [31:0]           ex_pc,
  input  logic [NUM_EXCP-1:0]   ex_excp,
  input  logic [31:0]           ex_badv,
  input  logic                  ex_ertn,
  input  logic                  have_intrpt,
  input  logic                  jump_excp_fail,
  input  logic                  excp_jump,
  output logic [CSR_BUS_WD-1:0] csr_bus,
  output logic                  ex_kill,
  output logic                  ex_stall,
  output logic                  flush
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RETRY = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0] state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  csr_bus_t   saved_reg, saved_next;

  logic        enc_sel;
  logic [5:0]  enc_ecode;
  logic [8:0]  enc_subecode;
  logic        enc_use_badv;
  logic [31:0] enc_badv;

  excp_prio_enc u_prio_enc (
    .excp        (ex_excp),
    .have_intrpt (have_intrpt),
    .ex_pc       (ex_pc),
    .ex_badv     (ex_badv),
    .sel         (enc_sel),
    .ecode       (enc_ecode),
    .subecode    (enc_subecode),
    .use_badv    (enc_use_badv),
    .badv        (enc_badv)
  );

  logic     excp_sel, ertn_sel;
  csr_bus_t live_bus, bus_out;

  assign excp_sel = ex_valid & enc_sel;
  assign ertn_sel = ex_valid & ex_ertn & ~enc_sel;

  always_comb begin
    live_bus = '0;
    if (excp_sel) begin
      live_bus.in_excp  = 1'b1;
      live_bus.ecode    = enc_ecode;
      live_bus.subecode = enc_subecode;
      live_bus.era      = ex_pc;
      live_bus.use_badv = enc_use_badv;
      live_bus.badv     = enc_badv;
    end else if (ertn_sel) begin
      live_bus.is_etrn = 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    saved_next = saved_reg;
    bus_out    = '0;
    ex_kill    = 1'b0;
    ex_stall   = 1'b0;
    flush      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        bus_out = live_bus;
        ex_kill = excp_sel;
        if (excp_sel || ertn_sel) begin
          saved_next = live_bus;
          if (jump_excp_fail) begin
            state_next = ST_RETRY;
          end else if (excp_jump) begin
            state_next = ST_DRAIN;
            cnt_next   = 4'(FLUSH_CYCLES);
          end else begin
            ex_stall = 1'b1;
          end
        end
      end
      ST_RETRY: begin
        bus_out  = saved_reg;
        ex_kill  = 1'b1;
        ex_stall = 1'b1;
        if (!jump_excp_fail && excp_jump) begin
          state_next = ST_DRAIN;
          cnt_next   = 4'(FLUSH_CYCLES);
        end
      end
      ST_DRAIN: begin
        flush    = 1'b1;
        ex_kill  = 1'b1;
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg <= 4'd1) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  assign csr_bus = bus_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      saved_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      saved_reg <= saved_next;
    end
  end

endmodule

// File: doc/excp_ctrl.md
# excp_ctrl

Exception/interrupt arbiter in the EXE stage and the producer of `csr_bus` consumed by the CSR file. Each cycle it takes the exception flags carried by the EXE instruction, the pending-interrupt indication and ERTN, and selects one event by priority. It packs Ecode, EsubCode, ERA and BADV onto `csr_bus`. It then sequences the pipeline flush, and replays the event when the CSR file rejects it because of a colliding CSR write.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: number of cycles `flush` stays high after an accepted event (1..15).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `ex_valid` in 1: an EXE instruction is present this cycle.
- `ex_pc` in 32: PC of the EXE instruction.
- `ex_excp` in 7: exception flags, one bit per cause:
  - [0] ADEF
  - [1] INE
  - [2] IPE
  - [3] SYS
  - [4] BRK
  - [5] ALE
  - [6] ADEM
- `ex_badv` in 32: faulting data address (used for ALE/ADEM).
- `ex_ertn` in 1: the EXE instruction is ERTN.
- `have_intrpt` in 1: the CSR file reports an enabled pending interrupt.
- `jump_excp_fail` in 1: the CSR file rejected this cycle's `in_excp`.
- `excp_jump` in 1: the CSR file accepted a redirect (exception or ERTN).
- `csr_bus` out `CSR_BUS_WD` (82): packed as {is_etrn, in_excp, ecode[5:0], subecode[8:0], era[31:0], use_badv, badv[31:0]}.
- `ex_kill` out 1: suppress the EXE instruction's writeback and memory side effects this cycle.
- `ex_stall` out 1: hold EXE and all older stages.
- `flush` out 1: invalidate IF/ID and the EXE pipeline register.

## Operation
States:
- IDLE: accept events.
- RETRY: re-present a saved event.
- DRAIN: flush is in progress.

Event selection in IDLE, valid only when `ex_valid`=1. Priority runs highest first:

| Priority | Event | ecode | subecode | use_badv / badv |
|---|---|---|---|---|
| 1 | interrupt (`have_intrpt`) | 0x00 | 0 | 0 |
| 2 | ADEF | 0x08 | 0 | use_badv=1, badv=`ex_pc` |
| 3 | INE | 0x0D | 0 | 0 |
| 4 | IPE | 0x0E | 0 | 0 |
| 5 | SYS | 0x0B | 0 | 0 |
| 6 | BRK | 0x0C | 0 | 0 |
| 7 | ALE | 0x09 | 0 | use_badv=1, badv=`ex_badv` |
| 8 | ADEM | 0x08 | 1 | use_badv=1, badv=`ex_badv` |
| 9 | ERTN (`ex_ertn`) | — | — | — |

- For an exception or interrupt: in_excp=1, is_etrn=0, era=`ex_pc`.
- For ERTN: is_etrn=1, in_excp=0, all other fields 0.
- Any field not listed is 0.
- When no event is selected, `csr_bus` is all-zero.

Event handling in IDLE:
- When an event is selected:
  - Drive `csr_bus` combinationally in the same cycle.
  - Assert `ex_kill` for any exception or interrupt.
  - Do not assert `ex_kill` for ERTN (it has no side effects).
  - Register the packed bus into `saved_bus`.
- Transitions out of IDLE:
  - `jump_excp_fail`=1 → RETRY.
  - `excp_jump`=1 → DRAIN, with the counter loaded to FLUSH_CYCLES.
  - Neither → stay in IDLE and re-evaluate next cycle. The instruction is still killed, and `ex_stall`=1 holds it.

RETRY:
- Drive `csr_bus` from `saved_bus` and assert `ex_stall`=1 and `ex_kill`=1.
- Transitions:
  - `excp_jump`=1 → DRAIN.
  - `jump_excp_fail`=1 again → stay in RETRY.
- Never re-sample the inputs while in RETRY.

DRAIN:
- Outputs: `flush`=1, `csr_bus`=0, `ex_kill`=1 (any `ex_valid` here is wrong-path).
- Decrement the counter each cycle. When the counter is 1 → IDLE.
- `have_intrpt` and any flags arriving in DRAIN are ignored.

Other rules:
- `ex_valid`=0 in IDLE → no event, even when `have_intrpt`=1. Interrupts attach only to a valid instruction.
- Reset in any state → IDLE immediately and `saved_bus` cleared. An in-progress retry or drain is abandoned.

## Timing
- Reset values:
  - `csr_bus`=0, `ex_kill`=0, `ex_stall`=0, `flush`=0.
  - State IDLE, counter 0, `saved_bus`=0.
- Event→CSR latency is 0 cycles: `csr_bus` is valid in the cycle the event is detected.
- Flush starts in the cycle after `excp_jump` and lasts exactly FLUSH_CYCLES cycles.
- Minimum spacing between two accepted events is FLUSH_CYCLES+1 cycles.
- In RETRY, `csr_bus` is stable and bit-identical to the rejected value until it is accepted.

## Structure
- Put these in `define.vh`:
  - `CSR_BUS_WD` (82).
  - The ecode constants INT, ADE, ALE, SYS, BRK, INE, IPE.
  - The subcodes ADEF=0, ADEM=1.
  - The `ex_excp` bit indices.
- One sub-module, `excp_prio_enc`: purely combinational, taking the flags plus `have_intrpt`/`ex_pc`/`ex_badv` and returning {sel, ecode, subecode, use_badv, badv}.
- Keep the FSM, counter and saved register in `excp_ctrl`.

## Test plan
- SYS: `ex_valid`=1, `ex_excp`=7'b0001000, `ex_pc`=0x1C000100, `excp_jump`=1 → `csr_bus` has in_excp=1, ecode=0x0B, era=0x1C000100; `ex_kill`=1; then `flush`=1 for exactly 2 cycles.
- Priority: ADEF+ALE+`have_intrpt` together → ecode=0x00 (interrupt). The same stimulus without the interrupt → ecode=0x08, subecode=0, badv=`ex_pc`.
- ADEM with `ex_badv`=0xDEADBEEC → ecode=0x08, subecode=1, use_badv=1, badv=0xDEADBEEC.
- Retry: `jump_excp_fail`=1 for 2 cycles, then `excp_jump`=1 → `ex_stall`=1 for 2 cycles, `csr_bus` held identical, then DRAIN.
- ERTN, no flags → is_etrn=1, in_excp=0, `ex_kill`=0, then flush. A new SYS arriving during DRAIN is ignored.
- Reset asserted in the middle of DRAIN → next cycle `flush`=0, `csr_bus`=0, state IDLE.
